// File: rtl/vedic_pkg.sv
// Shared widths and types for the Vedic multiplier family.
package vedic_pkg;
    localparam int unsigned OPW = 4;
    localparam int unsigned PRW = 8;

    typedef logic [OPW-1:0] operand_t;
    typedef logic [PRW-1:0] product_t;
endpackage

// File: rtl/vedic_mul_2bit.sv
// Combinational 2x2 Urdhva-Tiryagbhyam block: four AND terms and two half adders.
module vedic_mul_2bit (
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic [3:0] p
);
    logic c1;

    always_comb begin
        p[0] = x[0] & y[0];
        // crosswise terms feed the first half adder, vertical high term the second
        p[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
        c1   = (x[1] & y[0]) & (x[0] & y[1]);
        p[2] = (x[1] & y[1]) ^ c1;
        p[3] = (x[1] & y[1]) & c1;
    end
endmodule

// File: rtl/vedic_mul_4bit.sv
// Unsigned 4x4 Vedic multiplier: four 2x2 blocks, two ripple adders, registered product.
module vedic_mul_4bit
    import vedic_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic [PRW-1:0] s
);
    logic [3:0] q0, q1, q2, q3;
    logic [4:0] t;
    logic [4:0] tc;
    logic [5:0] ua, ub, us;
    logic [5:0] uc;
    product_t   s_next;

    vedic_mul_2bit u_q0 (.x(a[1:0]), .y(b[1:0]), .p(q0));
    vedic_mul_2bit u_q1 (.x(a[3:2]), .y(b[1:0]), .p(q1));
    vedic_mul_2bit u_q2 (.x(a[1:0]), .y(b[3:2]), .p(q2));
    vedic_mul_2bit u_q3 (.x(a[3:2]), .y(b[3:2]), .p(q3));

    // Cross sum t = q1 + q2 as a 4-bit ripple adder with carry into t[4].
    always_comb begin
        t  = '0;
        tc = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            t[i]    = q1[i] ^ q2[i] ^ tc[i];
            tc[i+1] = (q1[i] & q2[i]) | (tc[i] & (q1[i] ^ q2[i]));
        end
        t[4] = tc[4];
    end

    // Upper sum {q3, q0[3:2]} + t; its carry-out is always zero, so the chain stops at bit 5.
    always_comb begin
        ua = {q3, q0[3:2]};
        ub = {1'b0, t};
        us = '0;
        uc = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            us[i] = ua[i] ^ ub[i] ^ uc[i];
            if (i < 5)
                uc[i+1] = (ua[i] & ub[i]) | (uc[i] & (ua[i] ^ ub[i]));
        end
        s_next = {us, q0[1:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            s <= '0;
        else
            s <= s_next;
    end
endmodule

// File: tb/tb_vedic_mul_4bit.sv
// Self-checking bench for vedic_mul_4bit: directed table, reset corners, exhaustive and random sweeps.
module tb_vedic_mul_4bit;
    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] s;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [8];

    vedic_mul_4bit dut (.clk(clk), .rst(rst), .a(a), .b(b), .s(s));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model(input logic [3:0] x, input logic [3:0] y);
        int unsigned r;
        r = int'(x) * int'(y);
        return r[7:0];
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (a=%h b=%h)", name, act, exp, a, b);
        end
    endtask

    // Drive on the falling edge, confirm s has not moved yet, then check after the rising edge.
    task automatic apply(input string name, input logic [3:0] x, input logic [3:0] y,
                         input logic [7:0] prev, input logic [7:0] exp);
        @(negedge clk);
        a = x;
        b = y;
        #1 check({name, "_hold"}, s, prev);
        @(posedge clk);
        #1 check(name, s, exp);
    endtask

    initial begin
        logic [7:0] prev;

        vecs[0] = '{4'h4, 4'h4, 8'h10};
        vecs[1] = '{4'h2, 4'h9, 8'h12};
        vecs[2] = '{4'h9, 4'h9, 8'h51};
        vecs[3] = '{4'h0, 4'hF, 8'h00};
        vecs[4] = '{4'hF, 4'h0, 8'h00};
        vecs[5] = '{4'h1, 4'hD, 8'h0D};
        vecs[6] = '{4'hF, 4'hF, 8'hE1};
        vecs[7] = '{4'h1, 4'h1, 8'h01};

        rst = 1'b1;
        a   = 4'hF;
        b   = 4'hF;
        #1 check("reset_async", s, 8'h00);
        repeat (3) @(posedge clk);
        #1 check("reset_hold", s, 8'h00);

        @(negedge clk);
        rst = 1'b0;
        #1 check("reset_release_no_edge", s, 8'h00);
        @(posedge clk);
        #1 check("first_capture", s, 8'hE1);
        prev = 8'hE1;

        for (int i = 0; i < 8; i++) begin
            apply($sformatf("table%0d", i), vecs[i].a, vecs[i].b, prev, vecs[i].exp);
            prev = vecs[i].exp;
        end

        // Asynchronous reset mid-cycle while s holds 81.
        apply("pre_rst_81", 4'h9, 4'h9, prev, 8'h51);
        #2 rst = 1'b1;
        #1 check("rst_mid_cycle", s, 8'h00);
        @(posedge clk);
        #1 check("rst_held_over_edge", s, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check("rst_resume", s, 8'h51);
        prev = 8'h51;

        for (int i = 0; i < 256; i++) begin
            logic [7:0] ab;
            logic [7:0] exp;
            ab  = 8'(i);
            exp = model(ab[7:4], ab[3:0]);
            apply("sweep", ab[7:4], ab[3:0], prev, exp);
            prev = exp;
        end

        for (int i = 0; i < 64; i++) begin
            logic [3:0] x;
            logic [3:0] y;
            logic [7:0] exp;
            x   = 4'($urandom_range(0, 15));
            y   = 4'($urandom_range(0, 15));
            exp = model(x, y);
            apply("random", x, y, prev, exp);
            prev = exp;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
